uc_multiciclo: RTL and testbench

Multicycle control unit for the 64-bit RISC-V datapath. A Moore state machine decodes the instruction-register opcode and funct fields and sequences the datapath one step per cycle. In each state it drives the PC, IR, A/B, ALUOut and MDR load strobes, the ALU operation, the operand and writeback mux selects, and the memory write enable. It sits beside the datapath, between the instruction register and every register, mux and memory control input.

---
 rtl/uc_multiciclo.sv | 251 +++++++++++++++++++++++++
 tb/tb_uc_multiciclo.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uc_multiciclo.sv
// uc_multiciclo -- multicycle control unit for the 64-bit RISC-V datapath.
// Moore FSM that decodes the IR opcode/funct fields and sequences the
// datapath one step per cycle (only pc_write in BRANCH depends on z).
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   opcode/funct3/funct7_5  IR[6:0], IR[14:12], IR[30]
//   z                   ALU zero flag
//   pc_write, pc_src, old_pc_wr, load_ir, reg_a_wr, reg_b_wr, ulaout_wr,
//   mdr_wr, banco_reg_wr, data_memory_wr   datapath load/write strobes
//   seletor_ula, mux_a_sel, mux_b_sel, mux_banco_reg_sel   ALU op / mux selects
//   state, halted, illegal, retired        status outputs
module uc_multiciclo #(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7_5,
  input  logic        z,
  output logic        pc_write,
  output logic        pc_src,
  output logic        old_pc_wr,
  output logic        load_ir,
  output logic        reg_a_wr,
  output logic        reg_b_wr,
  output logic        ulaout_wr,
  output logic        mdr_wr,
  output logic [2:0]  seletor_ula,
  output logic [2:0]  mux_a_sel,
  output logic [2:0]  mux_b_sel,
  output logic [2:0]  mux_banco_reg_sel,
  output logic        banco_reg_wr,
  output logic        data_memory_wr,
  output logic [3:0]  state,
  output logic        halted,
  output logic        illegal,
  output logic [31:0] retired
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    EXEC_R = 4'd2,
    EXEC_I = 4'd3,
    ADDR   = 4'd4,
    MEM_LD = 4'd5,
    WB_LD  = 4'd6,
    MEM_SD = 4'd7,
    WB_ALU = 4'd8,
    BRANCH = 4'd9,
    LUI_WB = 4'd10,
    HALT   = 4'd15
  } state_t;

  localparam logic [2:0] W = MEM_WAIT[2:0];

  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;

  state_t      cur, nxt;
  logic [2:0]  cnt, cnt_nxt;
  logic        wait_done;
  logic        set_illegal;
  logic        retire;

  logic pc_write_c, old_pc_wr_c, load_ir_c, reg_a_wr_c, reg_b_wr_c;
  logic ulaout_wr_c, mdr_wr_c, banco_reg_wr_c, data_memory_wr_c;

  assign wait_done = (cnt == W);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur     <= FETCH;
      cnt     <= '0;
      illegal <= 1'b0;
      retired <= '0;
    end else begin
      cur <= nxt;
      cnt <= cnt_nxt;
      if (set_illegal) illegal <= 1'b1;
      if (retire)      retired <= retired + 32'd1;
    end
  end

  // Counter only runs in the two memory-wait states; it is zero everywhere
  // else, so entry into FETCH/MEM_LD always starts from 0.
  always_comb begin
    cnt_nxt = '0;
    if ((cur == FETCH || cur == MEM_LD) && !wait_done)
      cnt_nxt = cnt + 3'd1;
  end

  always_comb begin
    nxt               = cur;
    set_illegal       = 1'b0;
    retire            = 1'b0;
    pc_write_c        = 1'b0;
    pc_src            = 1'b0;
    old_pc_wr_c       = 1'b0;
    load_ir_c         = 1'b0;
    reg_a_wr_c        = 1'b0;
    reg_b_wr_c        = 1'b0;
    ulaout_wr_c       = 1'b0;
    mdr_wr_c          = 1'b0;
    banco_reg_wr_c    = 1'b0;
    data_memory_wr_c  = 1'b0;
    seletor_ula       = ALU_ADD;
    mux_a_sel         = '0;
    mux_b_sel         = '0;
    mux_banco_reg_sel = '0;

    unique case (cur)
      FETCH: begin
        if (wait_done) begin
          load_ir_c   = 1'b1;
          old_pc_wr_c = 1'b1;
          pc_write_c  = 1'b1;
          mux_b_sel   = 3'd1;
          nxt         = DECODE;
        end
      end

      DECODE: begin
        reg_a_wr_c  = 1'b1;
        reg_b_wr_c  = 1'b1;
        // Branch target precomputed here: OLD_PC + (imm<<1) into ALUOut.
        ulaout_wr_c = 1'b1;
        mux_a_sel   = 3'd2;
        mux_b_sel   = 3'd3;
        unique case (opcode)
          7'b0110011: nxt = EXEC_R;
          7'b0010011: begin
            if (funct3 == 3'b000) nxt = EXEC_I;
            else begin nxt = HALT; set_illegal = 1'b1; end
          end
          7'b0000011, 7'b0100011: begin
            if (funct3 == 3'b011) nxt = ADDR;
            else begin nxt = HALT; set_illegal = 1'b1; end
          end
          7'b1100011: begin
            if (funct3 == 3'b000 || funct3 == 3'b001) nxt = BRANCH;
            else begin nxt = HALT; set_illegal = 1'b1; end
          end
          7'b0110111: nxt = LUI_WB;
          7'b1110011: nxt = HALT;
          default: begin
            nxt         = HALT;
            set_illegal = 1'b1;
          end
        endcase
      end

      EXEC_R: begin
        ulaout_wr_c = 1'b1;
        mux_a_sel   = 3'd1;
        mux_b_sel   = 3'd0;
        nxt         = WB_ALU;
        casez ({funct3, funct7_5})
          4'b0000: seletor_ula = ALU_ADD;
          4'b0001: seletor_ula = ALU_SUB;
          4'b111?: seletor_ula = ALU_AND;
          4'b100?: seletor_ula = ALU_XOR;
          default: begin
            nxt         = HALT;
            set_illegal = 1'b1;
          end
        endcase
      end

      EXEC_I: begin
        ulaout_wr_c = 1'b1;
        mux_a_sel   = 3'd1;
        mux_b_sel   = 3'd2;
        nxt         = WB_ALU;
      end

      WB_ALU: begin
        banco_reg_wr_c = 1'b1;
        retire         = 1'b1;
        nxt            = FETCH;
      end

      ADDR: begin
        ulaout_wr_c = 1'b1;
        mux_a_sel   = 3'd1;
        mux_b_sel   = 3'd2;
        nxt         = (opcode == 7'b0000011) ? MEM_LD : MEM_SD;
      end

      MEM_LD: begin
        if (wait_done) begin
          mdr_wr_c = 1'b1;
          nxt      = WB_LD;
        end
      end

      WB_LD: begin
        banco_reg_wr_c    = 1'b1;
        mux_banco_reg_sel = 3'd1;
        retire            = 1'b1;
        nxt               = FETCH;
      end

      MEM_SD: begin
        data_memory_wr_c = 1'b1;
        retire           = 1'b1;
        nxt              = FETCH;
      end

      BRANCH: begin
        mux_a_sel   = 3'd1;
        mux_b_sel   = 3'd0;
        seletor_ula = ALU_SUB;
        pc_src      = 1'b1;
        pc_write_c  = (funct3 == 3'b001) ? !z : z;
        retire      = 1'b1;
        nxt         = FETCH;
      end

      LUI_WB: begin
        banco_reg_wr_c    = 1'b1;
        mux_banco_reg_sel = 3'd2;
        retire            = 1'b1;
        nxt               = FETCH;
      end

      HALT: nxt = HALT;

      default: nxt = FETCH;
    endcase
  end

  // Strobes are forced low combinationally so nothing is written while the
  // asynchronous reset is held, even in the W=0 FETCH cycle.
  assign pc_write       = pc_write_c       & ~reset;
  assign old_pc_wr      = old_pc_wr_c      & ~reset;
  assign load_ir        = load_ir_c        & ~reset;
  assign reg_a_wr       = reg_a_wr_c       & ~reset;
  assign reg_b_wr       = reg_b_wr_c       & ~reset;
  assign ulaout_wr      = ulaout_wr_c      & ~reset;
  assign mdr_wr         = mdr_wr_c         & ~reset;
  assign banco_reg_wr   = banco_reg_wr_c   & ~reset;
  assign data_memory_wr = data_memory_wr_c & ~reset;

  assign state  = cur;
  assign halted = (cur == HALT);

endmodule

// File: tb/tb_uc_multiciclo.sv
module tb_uc_multiciclo;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic        funct7_5 = 1'b0;
  logic        z = 1'b0;
  logic        pc_write, pc_src, old_pc_wr, load_ir, reg_a_wr, reg_b_wr;
  logic        ulaout_wr, mdr_wr, banco_reg_wr, data_memory_wr;
  logic [2:0]  seletor_ula, mux_a_sel, mux_b_sel, mux_banco_reg_sel;
  logic [3:0]  state;
  logic        halted, illegal;
  logic [31:0] retired;

  uc_multiciclo #(.MEM_WAIT(1)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .funct3(funct3),
    .funct7_5(funct7_5), .z(z), .pc_write(pc_write), .pc_src(pc_src),
    .old_pc_wr(old_pc_wr), .load_ir(load_ir), .reg_a_wr(reg_a_wr),
    .reg_b_wr(reg_b_wr), .ulaout_wr(ulaout_wr), .mdr_wr(mdr_wr),
    .seletor_ula(seletor_ula), .mux_a_sel(mux_a_sel), .mux_b_sel(mux_b_sel),
    .mux_banco_reg_sel(mux_banco_reg_sel), .banco_reg_wr(banco_reg_wr),
    .data_memory_wr(data_memory_wr), .state(state), .halted(halted),
    .illegal(illegal), .retired(retired)
  );

  always #5 clock = ~clock;

  // strobe vector bit order:
  // [9]pc_write [8]pc_src [7]old_pc_wr [6]load_ir [5]reg_a_wr [4]reg_b_wr
  // [3]ulaout_wr [2]mdr_wr [1]banco_reg_wr [0]data_memory_wr
  typedef struct packed {
    logic [3:0]  st;
    logic [9:0]  sb;
    logic [2:0]  alu;
    logic [2:0]  ma;
    logic [2:0]  mb;
    logic [2:0]  wb;
    logic        h;
    logic        il;
    logic [31:0] ret;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  logic [6:0] nxt_op = '0;
  logic [2:0] nxt_f3 = '0;
  logic       nxt_f7 = 1'b0;
  logic       nxt_z = 1'b0;
  logic       nxt_rst = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Monitor: every sampled cycle with a pending expectation is compared.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("state", {60'd0, state}, {60'd0, e.st});
        chk("strobes", {54'd0, pc_write, pc_src, old_pc_wr, load_ir, reg_a_wr,
                        reg_b_wr, ulaout_wr, mdr_wr, banco_reg_wr, data_memory_wr},
            {54'd0, e.sb});
        chk("selects", {52'd0, seletor_ula, mux_a_sel, mux_b_sel, mux_banco_reg_sel},
            {52'd0, e.alu, e.ma, e.mb, e.wb});
        chk("status", {30'd0, halted, illegal, retired}, {30'd0, e.h, e.il, e.ret});
      end
    end
  end

  task automatic set_ir(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    nxt_op = op; nxt_f3 = f3; nxt_f7 = f7;
  endtask

  // One clock cycle: drive pending inputs just after the edge, queue the
  // hand-computed outputs expected for this cycle.
  task automatic cyc(input logic [3:0] st, input logic [9:0] sb, input logic [2:0] alu,
                     input logic [2:0] ma, input logic [2:0] mb, input logic [2:0] wb,
                     input logic h, input logic il, input logic [31:0] ret);
    exp_t e;
    @(posedge clock);
    #1;
    reset = nxt_rst; opcode = nxt_op; funct3 = nxt_f3; funct7_5 = nxt_f7; z = nxt_z;
    e.st = st; e.sb = sb; e.alu = alu; e.ma = ma; e.mb = mb; e.wb = wb;
    e.h = h; e.il = il; e.ret = ret;
    q.push_back(e);
  endtask

  task automatic fetch(input logic [31:0] r);
    cyc(4'd0, 10'h000, 3'd1, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, r);
    cyc(4'd0, 10'h2C0, 3'd1, 3'd0, 3'd1, 3'd0, 1'b0, 1'b0, r);
  endtask

  task automatic decode(input logic [31:0] r);
    cyc(4'd1, 10'h038, 3'd1, 3'd2, 3'd3, 3'd0, 1'b0, 1'b0, r);
  endtask

  task automatic rtype(input logic [2:0] f3, input logic f7, input logic [2:0] alu,
                       input logic [31:0] r);
    set_ir(7'b0110011, f3, f7);
    fetch(r); decode(r);
    cyc(4'd2, 10'h008, alu, 3'd1, 3'd0, 3'd0, 1'b0, 1'b0, r);
    cyc(4'd8, 10'h002, 3'd1, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, r);
  endtask

  task automatic branch(input logic [2:0] f3, input logic zv, input logic [9:0] sb,
                        input logic [31:0] r);
    set_ir(7'b1100011, f3, 1'b0);
    fetch(r); decode(r);
    nxt_z = zv;
    cyc(4'd9, sb, 3'd2, 3'd1, 3'd0, 3'd0, 1'b0, 1'b0, r);
    nxt_z = 1'b0;
  endtask

  task automatic do_reset();
    nxt_rst = 1'b1;
    cyc(4'd0, 10'h000, 3'd1, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 32'd0);
    nxt_rst = 1'b0;
  endtask

  initial begin
    // reset state
    cyc(4'd0, 10'h000, 3'd1, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 32'd0);
    cyc(4'd0, 10'h000, 3'd1, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 32'd0);
    nxt_rst = 1'b0;

    rtype(3'b000, 1'b0, 3'b001, 32'd0);   // add x3,x1,x2
    rtype(3'b000, 1'b1, 3'b010, 32'd1);   // sub
    rtype(3'b100, 1'b0, 3'b100, 32'd2);   // xor

    // addi
    set_ir(7'b0010011, 3'b000, 1'b0);
    fetch(32'd3); decode(32'd3);
    cyc(4'd3, 10'h008, 3'd1, 3'd1, 3'd2, 3'd0, 1'b0, 1'b0, 32'd3);
    cyc(4'd8, 10'h002, 3'd1, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 32'd3);

    // ld 0x0000B183: 7 cycles, mdr_wr only in second MEM_LD cycle
    set_ir(7'b0000011, 3'b011, 1'b0);
    fetch(32'd4); decode(32'd4);
    cyc(4'd4, 10'h008, 3'd1, 3'd1, 3'd2, 3'd0, 1'b0, 1'b0, 32'd4);
    cyc(4'd5, 10'h000, 3'd1, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 32'd4);
    cyc(4'd5, 10'h004, 3'd1, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 32'd4);
    cyc(4'd6, 10'h002, 3'd1, 3'd0, 3'd0, 3'd1, 1'b0, 1'b0, 32'd4);

    // sd 0x0030B023: 5 cycles, one data_memory_wr pulse
    set_ir(7'b0100011, 3'b011, 1'b0);
    fetch(32'd5); decode(32'd5);
    cyc(4'd4, 10'h008, 3'd1, 3'd1, 3'd2, 3'd0, 1'b0, 1'b0, 32'd5);
    cyc(4'd7, 10'h001, 3'd1, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 32'd5);

    branch(3'b000, 1'b1, 10'h300, 32'd6); // beq taken
    branch(3'b000, 1'b0, 10'h100, 32'd7); // beq not taken
    branch(3'b001, 1'b0, 10'h300, 32'd8); // bne taken
    branch(3'b001, 1'b1, 10'h100, 32'd9); // bne not taken

    // lui
    set_ir(7'b0110111, 3'b000, 1'b0);
    fetch(32'd10); decode(32'd10);
    cyc(4'd10, 10'h002, 3'd1, 3'd0, 3'd0, 3'd2, 1'b0, 1'b0, 32'd10);

    // sd aborted by reset raised inside MEM_SD
    set_ir(7'b0100011, 3'b011, 1'b0);
    fetch(32'd11); decode(32'd11);
    cyc(4'd4, 10'h008, 3'd1, 3'd1, 3'd2, 3'd0, 1'b0, 1'b0, 32'd11);
    nxt_rst = 1'b1;
    cyc(4'd0, 10'h000, 3'd1, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 32'd0);
    cyc(4'd0, 10'h000, 3'd1, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 32'd0);
    nxt_rst = 1'b0;

    // ebreak: halted, not illegal
    set_ir(7'b1110011, 3'b000, 1'b0);
    fetch(32'd0); decode(32'd0);
    repeat (5) cyc(4'd15, 10'h000, 3'd1, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0, 32'd0);

    // undecoded opcode 0x7F: halted and illegal held for 20 cycles
    do_reset();
    set_ir(7'h7F, 3'b000, 1'b0);
    fetch(32'd0); decode(32'd0);
    repeat (20) cyc(4'd15, 10'h000, 3'd1, 3'd0, 3'd0, 3'd0, 1'b1, 1'b1, 32'd0);

    // R-type with undefined funct3: EXEC_R then HALT with illegal
    do_reset();
    set_ir(7'b0110011, 3'b001, 1'b0);
    fetch(32'd0); decode(32'd0);
    cyc(4'd2, 10'h008, 3'd1, 3'd1, 3'd0, 3'd0, 1'b0, 1'b0, 32'd0);
    repeat (3) cyc(4'd15, 10'h000, 3'd1, 3'd0, 3'd0, 3'd0, 1'b1, 1'b1, 32'd0);

    repeat (3) @(posedge clock);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
